// File: rtl/zap_fetch_sequencer_pkg.sv
// Shared state encoding, step constants and buffer entry layout for the fetch sequencer.
package zap_fetch_sequencer_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } fetch_state_t;

    localparam logic [31:0] ABORT_PAYLOAD = 32'd0;
    localparam logic [31:0] ARM_STEP      = 32'd4;
    localparam logic [31:0] THUMB_STEP    = 32'd2;

    typedef struct packed {
        logic        abort;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/zap_fetch_buffer.sv
// Synchronous FIFO with registered storage; head is read directly from the entry array.
module zap_fetch_buffer #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/zap_fetch_sequencer.sv
// Fetch request sequencer: owns the fetch PC, issues credit-limited in-order
// requests, drops stale responses after a redirect and buffers the rest.
module zap_fetch_sequencer
    import zap_fetch_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_cpsr_t,
    input  logic        i_stall,
    output logic        o_req,
    output logic [31:0] o_req_addr,
    input  logic        i_ack,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_instr,
    input  logic        i_rsp_abort,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_instr_abort
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    fetch_state_t state_q, state_d;
    logic [31:0]  next_pc;
    logic [CW-1:0] discard;
    logic          pending_stale;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] in_use;
    logic          ack, drop, enq, can_issue, out_pop;
    logic          pcq_full, pcq_empty, out_full, out_empty;
    logic [31:0]   rsp_pc;
    fetch_entry_t  rsp_entry, head;

    assign ack       = o_req & i_ack;
    assign drop      = (discard != '0);
    assign enq       = i_rsp_valid & ~i_redirect & ~drop;
    assign in_use    = SW'(outstanding) + SW'(fifo_count) + SW'(o_req);
    assign can_issue = (state_q == RUN) & ~i_redirect & (~o_req | i_ack) & (in_use < SW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_redirect)              state_d = RUN;
        else if (enq && i_rsp_abort) state_d = SLEEP;
    end

    // Request is held until acked; a new one may be raised in the ack cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_req      <= 1'b0;
            o_req_addr <= RESET_VECTOR;
            next_pc    <= RESET_VECTOR;
        end else begin
            if (can_issue) begin
                o_req      <= 1'b1;
                o_req_addr <= next_pc;
            end else if (ack) begin
                o_req <= 1'b0;
            end
            if (i_redirect)     next_pc <= i_redirect_pc;
            else if (can_issue) next_pc <= next_pc + (i_cpsr_t ? THUMB_STEP : ARM_STEP);
        end
    end

    // Responses for requests issued before a redirect are counted here and dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            discard       <= '0;
            pending_stale <= 1'b0;
        end else if (i_redirect) begin
            discard       <= outstanding - CW'(i_rsp_valid) + CW'(ack);
            pending_stale <= o_req & ~i_ack;
        end else begin
            discard <= discard - CW'(i_rsp_valid & drop) + CW'(ack & pending_stale);
            if (ack) pending_stale <= 1'b0;
        end
    end

    zap_fetch_buffer #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (i_clk),
        .reset   (i_reset),
        .push    (ack),
        .pop     (i_rsp_valid),
        .flush   (1'b0),
        .wr_data (o_req_addr),
        .rd_data (rsp_pc),
        .full    (pcq_full),
        .empty   (pcq_empty),
        .count   (outstanding)
    );

    assign rsp_entry = '{abort: i_rsp_abort, pc: rsp_pc,
                         instr: (i_rsp_abort ? ABORT_PAYLOAD : i_rsp_instr)};
    assign out_pop   = o_valid & ~i_stall;

    zap_fetch_buffer #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .push    (enq),
        .pop     (out_pop),
        .flush   (i_redirect),
        .wr_data (rsp_entry),
        .rd_data (head),
        .full    (out_full),
        .empty   (out_empty),
        .count   (fifo_count)
    );

    assign o_valid       = ~out_empty;
    assign o_instruction = head.instr;
    assign o_pc          = head.pc;
    assign o_instr_abort = o_valid & head.abort;

    a_out_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(enq && out_full && !out_pop));
    a_pcq_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(ack && pcq_full && !i_rsp_valid));
    a_rsp_has_request: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_rsp_valid && pcq_empty));

endmodule

// File: tb/tb_zap_fetch_sequencer.sv
// Directed testbench for zap_fetch_sequencer with a behavioural I-cache responder.
module tb_zap_fetch_sequencer;

    logic        clk = 1'b0;
    logic        i_reset, i_redirect, i_cpsr_t, i_stall, i_ack;
    logic [31:0] i_redirect_pc;
    logic        i_rsp_valid, i_rsp_abort;
    logic [31:0] i_rsp_instr;
    logic        o_req, o_valid, o_instr_abort;
    logic [31:0] o_req_addr, o_instruction, o_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        abort;
    } pop_t;

    logic [31:0] req_log [$];
    pop_t        pop_log [$];
    logic [31:0] rsp_q   [$];

    logic        ack_en, rsp_hold, abort_en;
    logic [31:0] abort_addr;
    logic        ack_q;
    logic [31:0] ack_addr_q, rsp_addr;
    int          tests = 0;
    int          errors = 0;

    zap_fetch_sequencer dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_cpsr_t      (i_cpsr_t),
        .i_stall       (i_stall),
        .o_req         (o_req),
        .o_req_addr    (o_req_addr),
        .i_ack         (i_ack),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_instr   (i_rsp_instr),
        .i_rsp_abort   (i_rsp_abort),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_instr_abort (o_instr_abort)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hEA00_0000 | (a & 32'h00FF_FFFF);
    endfunction

    // I-cache model: acks while enabled, answers one cycle after the ack, in order.
    initial begin
        ack_q = 1'b0;
        ack_addr_q = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_q) rsp_q.push_back(ack_addr_q);
            if (i_reset) begin
                rsp_q.delete();
                i_rsp_valid = 1'b0;
                i_rsp_instr = 32'd0;
                i_rsp_abort = 1'b0;
            end else if (!rsp_hold && rsp_q.size() > 0) begin
                rsp_addr    = rsp_q.pop_front();
                i_rsp_valid = 1'b1;
                i_rsp_instr = instr_of(rsp_addr);
                i_rsp_abort = abort_en && (rsp_addr == abort_addr);
            end else begin
                i_rsp_valid = 1'b0;
                i_rsp_instr = 32'd0;
                i_rsp_abort = 1'b0;
            end
            i_ack      = ack_en && o_req;
            ack_q      = i_ack && !i_reset;
            ack_addr_q = o_req_addr;
        end
    end

    // Records accepted requests and consumed head entries.
    initial forever begin
        @(negedge clk);
        if (!i_reset) begin
            if (o_req && i_ack) req_log.push_back(o_req_addr);
            if (o_valid && !i_stall) pop_log.push_back('{o_pc, o_instruction, o_instr_abort});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        i_redirect = 1'b0;
        step(2);
        req_log.delete();
        pop_log.delete();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        ack_en  = 1'b0;
        step(3);
        tests++;
        if (o_req !== 1'b0 || o_valid !== 1'b0 || o_instr_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b abort=%b, want 0 0 0", o_req, o_valid, o_instr_abort);
        end
        tests++;
        if (o_req_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00000000", o_req_addr);
        end
        i_reset = 1'b0;
        step(1);
        tests++;
        if (o_req !== 1'b1 || o_req_addr !== 32'd0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000000", o_req, o_req_addr);
        end
        step(3);
        tests++;
        if (o_req !== 1'b1 || o_req_addr !== 32'd0) begin
            errors++;
            $display("FAIL req_hold_unacked: req=%b addr=%h, want 1 00000000", o_req, o_req_addr);
        end
    endtask

    task automatic test_stream(input logic thumb);
        logic [31:0] s;
        s = thumb ? 32'd2 : 32'd4;
        i_cpsr_t = thumb;
        ack_en   = 1'b1;
        do_reset();
        step(20);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (req_log.size() <= i) begin
                errors++;
                $display("FAIL stream_req[%0d] t=%b: missing, want %h", i, thumb, s * i);
            end else if (req_log[i] !== s * i) begin
                errors++;
                $display("FAIL stream_req[%0d] t=%b: got %h want %h", i, thumb, req_log[i], s * i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (pop_log.size() <= i) begin
                errors++;
                $display("FAIL stream_pop[%0d] t=%b: missing, want pc %h", i, thumb, s * i);
            end else if (pop_log[i].pc !== s * i || pop_log[i].instr !== instr_of(s * i)
                         || pop_log[i].abort !== 1'b0) begin
                errors++;
                $display("FAIL stream_pop[%0d] t=%b: got pc %h instr %h abort %b, want pc %h instr %h abort 0",
                         i, thumb, pop_log[i].pc, pop_log[i].instr, pop_log[i].abort, s * i, instr_of(s * i));
            end
        end
        i_cpsr_t = 1'b0;
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        ack_en  = 1'b1;
        do_reset();
        step(12);
        tests++;
        if (req_log.size() != 2) begin
            errors++;
            $display("FAIL stall_req_count: got %0d want 2", req_log.size());
        end
        tests++;
        if (o_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_low: got %b want 0", o_req);
        end
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'd0 || o_instruction !== instr_of(32'd0)) begin
            errors++;
            $display("FAIL stall_head: valid=%b pc=%h instr=%h, want 1 00000000 %h",
                     o_valid, o_pc, o_instruction, instr_of(32'd0));
        end
        tests++;
        if (pop_log.size() != 0) begin
            errors++;
            $display("FAIL stall_no_pop: got %0d pops want 0", pop_log.size());
        end
        i_stall = 1'b0;
        step(20);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (pop_log.size() <= i) begin
                errors++;
                $display("FAIL stall_release_pop[%0d]: missing, want pc %h", i, 4 * i);
            end else if (pop_log[i].pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_release_pop[%0d]: got pc %h want %h", i, pop_log[i].pc, 4 * i);
            end
        end
    endtask

    task automatic test_redirect();
        ack_en   = 1'b1;
        rsp_hold = 1'b1;
        do_reset();
        step(4);
        tests++;
        if (req_log.size() != 2 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_setup: %0d acked, req=%b, want 2 and 0", req_log.size(), o_req);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        rsp_hold      = 1'b0;
        step(1);
        i_redirect = 1'b0;
        pop_log.delete();
        tests++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b want 0", o_valid);
        end
        step(20);
        tests++;
        if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_req: %0d requests, want third at 00000100", req_log.size());
        end
        tests++;
        if (pop_log.size() < 2) begin
            errors++;
            $display("FAIL redirect_pop: got %0d pops want >=2", pop_log.size());
        end else if (pop_log[0].pc !== 32'h100 || pop_log[0].instr !== instr_of(32'h100)
                     || pop_log[1].pc !== 32'h104) begin
            errors++;
            $display("FAIL redirect_pop: got %h/%h then %h, want 00000100/%h then 00000104",
                     pop_log[0].pc, pop_log[0].instr, pop_log[1].pc, instr_of(32'h100));
        end
    endtask

    task automatic test_abort();
        ack_en     = 1'b1;
        abort_en   = 1'b1;
        abort_addr = 32'h8;
        do_reset();
        step(30);
        tests++;
        if (req_log.size() != 4 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_sleep: %0d requests req=%b, want 4 and 0", req_log.size(), o_req);
        end
        tests++;
        if (pop_log.size() != 4) begin
            errors++;
            $display("FAIL abort_pops: got %0d want 4", pop_log.size());
        end else if (pop_log[2].pc !== 32'h8 || pop_log[2].abort !== 1'b1 || pop_log[2].instr !== 32'd0
                     || pop_log[1].abort !== 1'b0 || pop_log[3].pc !== 32'hC) begin
            errors++;
            $display("FAIL abort_entry: got pc %h abort %b instr %h, want 00000008 1 00000000",
                     pop_log[2].pc, pop_log[2].abort, pop_log[2].instr);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h18;
        step(1);
        i_redirect = 1'b0;
        req_log.delete();
        pop_log.delete();
        step(20);
        tests++;
        if (req_log.size() < 2 || req_log[0] !== 32'h18 || req_log[1] !== 32'h1C) begin
            errors++;
            $display("FAIL abort_resume_req: %0d requests, want 00000018 then 0000001c", req_log.size());
        end
        tests++;
        if (pop_log.size() < 1 || pop_log[0].pc !== 32'h18 || pop_log[0].abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_resume_pop: %0d pops, want first pc 00000018 clean", pop_log.size());
        end
        abort_en = 1'b0;
    endtask

    task automatic test_reset_midflight();
        i_stall = 1'b1;
        ack_en  = 1'b1;
        do_reset();
        step(1);
        step(1);
        ack_en = 1'b0;
        step(3);
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'd0 || o_req !== 1'b1 || o_req_addr !== 32'h4) begin
            errors++;
            $display("FAIL midflight_setup: valid=%b pc=%h req=%b addr=%h, want 1 00000000 1 00000004",
                     o_valid, o_pc, o_req, o_req_addr);
        end
        i_reset = 1'b1;
        step(1);
        tests++;
        if (o_req !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: req=%b valid=%b want 0 0", o_req, o_valid);
        end
        req_log.delete();
        pop_log.delete();
        i_reset = 1'b0;
        i_stall = 1'b0;
        ack_en  = 1'b1;
        step(1);
        tests++;
        if (o_req !== 1'b1 || o_req_addr !== 32'd0) begin
            errors++;
            $display("FAIL midflight_restart: req=%b addr=%h want 1 00000000", o_req, o_req_addr);
        end
        step(15);
        tests++;
        if (pop_log.size() < 1 || pop_log[0].pc !== 32'd0) begin
            errors++;
            $display("FAIL midflight_first_pop: %0d pops, want first pc 00000000", pop_log.size());
        end
    endtask

    initial begin
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_cpsr_t      = 1'b0;
        i_stall       = 1'b0;
        i_ack         = 1'b0;
        i_rsp_valid   = 1'b0;
        i_rsp_instr   = 32'd0;
        i_rsp_abort   = 1'b0;
        ack_en        = 1'b0;
        rsp_hold      = 1'b0;
        abort_en      = 1'b0;
        abort_addr    = 32'd0;

        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_stall();
        test_redirect();
        test_abort();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
